// File: rtl/mul_pipe_stage.sv
// One registered MUL pipeline stage: carries the product and its instruction
// metadata forward one cycle, with hold, kill and exception gating.
package mul_pipe_pkg;
    typedef struct packed {
        logic        itlb_miss;
        logic        bus_error;
        logic        addr_val;
        logic [31:0] xcpt_addr;
    } fetch_xcpt_t;

    typedef struct packed {
        logic        illegal_instr;
        logic [31:0] xcpt_pc;
    } decode_xcpt_t;

    typedef struct packed {
        logic        xcpt_overflow;
        logic [31:0] xcpt_pc;
    } mul_xcpt_t;
endpackage

module mul_pipe_stage
    import mul_pipe_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 5,
    parameter int ROB_ID_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    stall,
    input  logic                    instr_valid_in,
    input  logic [ROB_ID_WIDTH-1:0] instr_id_in,
    input  logic [PC_WIDTH-1:0]     program_counter_in,
    input  logic [ADDR_WIDTH-1:0]   dest_reg_in,
    input  logic [DATA_WIDTH-1:0]   data_result_in,
    input  fetch_xcpt_t             xcpt_fetch_in,
    input  decode_xcpt_t            xcpt_decode_in,
    input  mul_xcpt_t               xcpt_mul_in,
    output logic                    instr_valid_out,
    output logic [ROB_ID_WIDTH-1:0] instr_id_out,
    output logic [PC_WIDTH-1:0]     program_counter_out,
    output logic [ADDR_WIDTH-1:0]   dest_reg_out,
    output logic [DATA_WIDTH-1:0]   data_result_out,
    output fetch_xcpt_t             xcpt_fetch_out,
    output decode_xcpt_t            xcpt_decode_out,
    output mul_xcpt_t               xcpt_mul_out
);

    logic                    valid_q,  valid_d;
    logic [ROB_ID_WIDTH-1:0] id_q,     id_d;
    logic [PC_WIDTH-1:0]     pc_q,     pc_d;
    logic [ADDR_WIDTH-1:0]   dest_q,   dest_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    fetch_xcpt_t             xfetch_q, xfetch_d;
    decode_xcpt_t            xdec_q,   xdec_d;
    mul_xcpt_t               xmul_q,   xmul_d;

    // Flush beats stall; payload simply holds on flush since it is don't-care once valid drops.
    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        pc_d     = pc_q;
        dest_d   = dest_q;
        data_d   = data_q;
        xfetch_d = xfetch_q;
        xdec_d   = xdec_q;
        xmul_d   = xmul_q;
        if (flush) begin
            valid_d  = 1'b0;
            xfetch_d = '0;
            xdec_d   = '0;
            xmul_d   = '0;
        end else if (!stall) begin
            valid_d  = instr_valid_in;
            id_d     = instr_id_in;
            pc_d     = program_counter_in;
            dest_d   = dest_reg_in;
            data_d   = data_result_in;
            xfetch_d = instr_valid_in ? xcpt_fetch_in  : '0;
            xdec_d   = instr_valid_in ? xcpt_decode_in : '0;
            xmul_d   = instr_valid_in ? xcpt_mul_in    : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            id_q     <= '0;
            pc_q     <= '0;
            dest_q   <= '0;
            data_q   <= '0;
            xfetch_q <= '0;
            xdec_q   <= '0;
            xmul_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            id_q     <= id_d;
            pc_q     <= pc_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            xfetch_q <= xfetch_d;
            xdec_q   <= xdec_d;
            xmul_q   <= xmul_d;
        end
    end

    assign instr_valid_out     = valid_q;
    assign instr_id_out        = id_q;
    assign program_counter_out = pc_q;
    assign dest_reg_out        = dest_q;
    assign data_result_out     = data_q;
    assign xcpt_fetch_out      = xfetch_q;
    assign xcpt_decode_out     = xdec_q;
    assign xcpt_mul_out        = xmul_q;

endmodule

// File: tb/tb_mul_pipe_stage.sv
// Directed bench for mul_pipe_stage: reset, pass-through, gating, stall,
// flush and streaming, with hand-computed expected values.
module tb_mul_pipe_stage;
    import mul_pipe_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         stall = 1'b0;
    logic         instr_valid_in;
    logic [2:0]   instr_id_in;
    logic [31:0]  program_counter_in;
    logic [4:0]   dest_reg_in;
    logic [63:0]  data_result_in;
    fetch_xcpt_t  xcpt_fetch_in;
    decode_xcpt_t xcpt_decode_in;
    mul_xcpt_t    xcpt_mul_in;
    logic         instr_valid_out;
    logic [2:0]   instr_id_out;
    logic [31:0]  program_counter_out;
    logic [4:0]   dest_reg_out;
    logic [63:0]  data_result_out;
    fetch_xcpt_t  xcpt_fetch_out;
    decode_xcpt_t xcpt_decode_out;
    mul_xcpt_t    xcpt_mul_out;

    int n_checks = 0;
    int n_pass   = 0;

    mul_pipe_stage dut (
        .clock               (clock),
        .reset               (reset),
        .flush               (flush),
        .stall               (stall),
        .instr_valid_in      (instr_valid_in),
        .instr_id_in         (instr_id_in),
        .program_counter_in  (program_counter_in),
        .dest_reg_in         (dest_reg_in),
        .data_result_in      (data_result_in),
        .xcpt_fetch_in       (xcpt_fetch_in),
        .xcpt_decode_in      (xcpt_decode_in),
        .xcpt_mul_in         (xcpt_mul_in),
        .instr_valid_out     (instr_valid_out),
        .instr_id_out        (instr_id_out),
        .program_counter_out (program_counter_out),
        .dest_reg_out        (dest_reg_out),
        .data_result_out     (data_result_out),
        .xcpt_fetch_out      (xcpt_fetch_out),
        .xcpt_decode_out     (xcpt_decode_out),
        .xcpt_mul_out        (xcpt_mul_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        instr_valid_in     = 1'b1;
        instr_id_in        = 3'd6;
        program_counter_in = 32'hDEAD_BEE0;
        dest_reg_in        = 5'd31;
        data_result_in     = 64'hFFFF_FFFF_FFFF_FFFF;
        xcpt_fetch_in      = '{itlb_miss: 1'b1, bus_error: 1'b0, addr_val: 1'b0, xcpt_addr: 32'hDEAD_BEE0};
        xcpt_decode_in     = '0;
        xcpt_mul_in        = '{xcpt_overflow: 1'b1, xcpt_pc: 32'hDEAD_BEE0};

        // Async reset with live inputs, before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 64'(instr_valid_out), 64'd0);
        chk("rst_id",    64'(instr_id_out), 64'd0);
        chk("rst_pc",    64'(program_counter_out), 64'd0);
        chk("rst_data",  data_result_out, 64'd0);
        chk("rst_itlb",  64'(xcpt_fetch_out.itlb_miss), 64'd0);
        chk("rst_ovf",   64'(xcpt_mul_out.xcpt_overflow), 64'd0);
        tick();
        tick();
        chk("rst_hold_valid", 64'(instr_valid_out), 64'd0);
        chk("rst_hold_data",  data_result_out, 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("rel_noedge_valid", 64'(instr_valid_out), 64'd0);
        tick();
        chk("rel_load_valid", 64'(instr_valid_out), 64'd1);
        chk("rel_load_id",    64'(instr_id_out), 64'd6);
        chk("rel_load_data",  data_result_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rel_load_dest",  64'(dest_reg_out), 64'd31);
        chk("rel_load_itlb",  64'(xcpt_fetch_out.itlb_miss), 64'd1);

        // Pass-through with one cycle latency.
        instr_id_in        = 3'd5;
        program_counter_in = 32'h0000_1000;
        dest_reg_in        = 5'd7;
        data_result_in     = 64'h0000_0001_0000_0002;
        xcpt_fetch_in      = '0;
        xcpt_mul_in        = '{xcpt_overflow: 1'b1, xcpt_pc: 32'h0000_1000};
        #1;
        chk("pt_before_edge_id", 64'(instr_id_out), 64'd6);
        tick();
        chk("pt_valid", 64'(instr_valid_out), 64'd1);
        chk("pt_id",    64'(instr_id_out), 64'd5);
        chk("pt_pc",    64'(program_counter_out), 64'h1000);
        chk("pt_dest",  64'(dest_reg_out), 64'd7);
        chk("pt_data",  data_result_out, 64'h0000_0001_0000_0002);
        chk("pt_ovf",   64'(xcpt_mul_out.xcpt_overflow), 64'd1);
        chk("pt_xpc",   64'(xcpt_mul_out.xcpt_pc), 64'h1000);
        chk("pt_itlb",  64'(xcpt_fetch_out.itlb_miss), 64'd0);

        // Invalid instruction: exceptions gated, payload still loads.
        instr_valid_in     = 1'b0;
        program_counter_in = 32'h0000_2000;
        data_result_in     = 64'h8000_0000_0000_0001;
        xcpt_fetch_in      = '{itlb_miss: 1'b1, bus_error: 1'b1, addr_val: 1'b1, xcpt_addr: 32'h2000};
        xcpt_decode_in     = '{illegal_instr: 1'b1, xcpt_pc: 32'h2000};
        tick();
        chk("inv_valid",   64'(instr_valid_out), 64'd0);
        chk("inv_fetch",   64'(xcpt_fetch_out), 64'd0);
        chk("inv_decode",  64'(xcpt_decode_out), 64'd0);
        chk("inv_mul",     64'(xcpt_mul_out), 64'd0);
        chk("inv_pc_load", 64'(program_counter_out), 64'h2000);
        chk("inv_data",    data_result_out, 64'h8000_0000_0000_0001);

        // Stall holds for three cycles, then the new value loads.
        instr_valid_in = 1'b1;
        instr_id_in    = 3'd2;
        xcpt_fetch_in  = '0;
        xcpt_decode_in = '0;
        xcpt_mul_in    = '0;
        tick();
        chk("stl_load_id", 64'(instr_id_out), 64'd2);
        stall       = 1'b1;
        instr_id_in = 3'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stl_hold_id%0d", i), 64'(instr_id_out), 64'd2);
        end
        stall = 1'b0;
        tick();
        chk("stl_release_id", 64'(instr_id_out), 64'd3);

        // Flush together with stall clears valid and exceptions.
        xcpt_mul_in = '{xcpt_overflow: 1'b1, xcpt_pc: 32'h3000};
        tick();
        chk("fl_pre_ovf", 64'(xcpt_mul_out.xcpt_overflow), 64'd1);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        chk("fl_valid", 64'(instr_valid_out), 64'd0);
        chk("fl_ovf",   64'(xcpt_mul_out.xcpt_overflow), 64'd0);
        chk("fl_mul",   64'(xcpt_mul_out), 64'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Back-to-back stream, no bubbles.
        xcpt_mul_in = '0;
        for (int i = 0; i < 4; i++) begin
            instr_id_in    = 3'(i);
            data_result_in = 64'(i) << 40;
            tick();
            chk($sformatf("str_valid%0d", i), 64'(instr_valid_out), 64'd1);
            chk($sformatf("str_id%0d", i), 64'(instr_id_out), 64'(i));
            chk($sformatf("str_data%0d", i), data_result_out, 64'(i) << 40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
